// File: rtl/cpu_phase_sequencer.sv
// One-hot N-phase machine-cycle sequencer with halt/resume and a retired-cycle counter.
// Define CPU_SEQ_WAIT_EN to add phase-1 memory wait states, timeout and the sticky bus_err.
module cpu_phase_sequencer #(
  parameter int unsigned PHASES    = 3,
  parameter int unsigned WAIT_MAX  = 15,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 halt_req,
  input  logic                 resume,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic [PHASES-1:0]    phase,
  output logic                 cycle_stb,
  output logic                 mem_stb,
  output logic                 exec_stb,
  output logic                 halted,
  output logic                 bus_err,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  if (PHASES < 3)   begin : g_bad_phases $error("PHASES must be >= 3"); end
  if (WAIT_MAX < 1) begin : g_bad_wait   $error("WAIT_MAX must be >= 1"); end

  typedef enum logic [1:0] {START, RUN, HALTED} state_e;

  state_e                 state_q, state_d;
  logic [PHASES-1:0]      phase_q, phase_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   stall;

`ifdef CPU_SEQ_WAIT_EN
  localparam int unsigned WW = $clog2(WAIT_MAX + 1);

  logic [WW-1:0] wait_q, wait_d;
  logic          bus_err_q, bus_err_d;
  logic          timeout;

  // Once the counter hits WAIT_MAX the access is forced to complete this clock.
  assign timeout = phase_q[1] && (wait_q == WW'(WAIT_MAX));
  assign stall   = phase_q[1] && mem_req && !mem_ready && !timeout;
  assign mem_stb = phase_q[1] & (~mem_req | mem_ready | timeout);
  assign bus_err = bus_err_q;

  always_comb begin
    wait_d    = '0;
    bus_err_d = bus_err_q;
    if (stall) begin
      wait_d = wait_q + 1'b1;
    end else if (timeout) begin
      bus_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end
`else
  logic unused_mem_inputs;

  assign unused_mem_inputs = ^{mem_ready, mem_req};
  assign stall             = 1'b0;
  assign mem_stb           = phase_q[1];
  assign bus_err           = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      START: begin
        state_d = RUN;
        phase_d = PHASES'(1);
      end
      RUN: begin
        if (!stall) begin
          if (phase_q[PHASES-1]) begin
            cnt_d = cnt_q + 1'b1;
            if (halt_req) begin
              state_d = HALTED;
              phase_d = '0;
            end else begin
              phase_d = PHASES'(1);
            end
          end else begin
            phase_d = {phase_q[PHASES-2:0], 1'b0};
          end
        end
      end
      HALTED: begin
        if (resume) begin
          state_d = RUN;
          phase_d = PHASES'(1);
        end
      end
      default: begin
        state_d = START;
        phase_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= START;
      phase_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  assign phase       = phase_q;
  assign cycle_stb   = phase_q[0];
  assign exec_stb    = phase_q[PHASES-1];
  assign halted      = (state_q == HALTED);
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Bench for cpu_phase_sequencer: directed vector table, randomized run against a
// phase-index reference model, and hand sequences for waits, timeout, async reset and wrap.
module tb_cpu_phase_sequencer;

  localparam int unsigned P  = 5;
  localparam int unsigned WM = 4;
  localparam int unsigned CW = 4;
`ifdef CPU_SEQ_WAIT_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          halt_req = 1'b0;
  logic          resume = 1'b0;
  logic          mem_req = 1'b0;
  logic          mem_ready = 1'b0;
  logic [P-1:0]  phase;
  logic          cycle_stb, mem_stb, exec_stb, halted, bus_err;
  logic [CW-1:0] cycle_count;

  int total = 0;
  int bad   = 0;

  cpu_phase_sequencer #(.PHASES(P), .WAIT_MAX(WM), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .halt_req   (halt_req),
    .resume     (resume),
    .mem_req    (mem_req),
    .mem_ready  (mem_ready),
    .phase      (phase),
    .cycle_stb  (cycle_stb),
    .mem_stb    (mem_stb),
    .exec_stb   (exec_stb),
    .halted     (halted),
    .bus_err    (bus_err),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: run state (0 start, 1 run, 2 halted), phase index, waits, count.
  int m_st, m_ph, m_wt, m_cnt;
  bit m_berr;

  function automatic logic [P-1:0] m_phase();
    logic [P-1:0] v;
    v = '0;
    if (m_st == 1) v[m_ph] = 1'b1;
    return v;
  endfunction

  function automatic bit m_timeout();
    return WEN && (m_st == 1) && (m_ph == 1) && (m_wt == int'(WM));
  endfunction

  function automatic bit m_mstb();
    return (m_st == 1) && (m_ph == 1) && (!WEN || !mem_req || mem_ready || m_timeout());
  endfunction

  task automatic m_reset();
    m_st = 0; m_ph = 0; m_wt = 0; m_cnt = 0; m_berr = 0;
  endtask

  task automatic m_step();
    bit to;
    to = m_timeout();
    case (m_st)
      0: begin m_st = 1; m_ph = 0; end
      2: if (resume) begin m_st = 1; m_ph = 0; end
      default: begin
        if (m_ph == 1 && WEN && mem_req && !mem_ready && !to) begin
          m_wt++;
        end else if (m_ph == int'(P) - 1) begin
          m_cnt = (m_cnt + 1) % (1 << CW);
          if (halt_req) m_st = 2;
          else          m_ph = 0;
        end else begin
          if (m_ph == 1) begin
            if (to) m_berr = 1;
            m_wt = 0;
          end
          m_ph++;
        end
      end
    endcase
  endtask

  task automatic check_model();
    logic [P-1:0] ep;
    ep = m_phase();
    chk("rnd_phase", phase, ep);
    chk("rnd_cycle_stb", cycle_stb, ep[0]);
    chk("rnd_exec_stb", exec_stb, ep[P-1]);
    chk("rnd_mem_stb", mem_stb, m_mstb());
    chk("rnd_halted", halted, (m_st == 2));
    chk("rnd_bus_err", bus_err, m_berr);
    chk("rnd_count", cycle_count, m_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; halt_req = 0; resume = 0; mem_req = 0; mem_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_phase", phase, 0);
    chk("rst_strobes", {cycle_stb, mem_stb, exec_stb, halted, bus_err}, 0);
    chk("rst_count", cycle_count, 0);
    reset = 1'b1;
    m_reset();
  endtask

  task automatic to_phase0(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (phase[0]) begin ok = 1; break; end
      tick();
    end
    chk(name, ok, 1);
  endtask

  // Measures one machine cycle starting on its phase[0] clock; ready_after<0 means never ready.
  task automatic measure(input int ready_after, output int p1, output int stbs,
                         output int stb_at, output int len);
    p1 = 0; stbs = 0; stb_at = -1; len = 0;
    for (int i = 0; i < 40; i++) begin
      mem_ready = phase[1] && (p1 == ready_after);
      #1;
      if (phase[1]) p1++;
      if (mem_stb) begin stbs++; stb_at = p1; end
      len++;
      tick();
      if (phase[0]) break;
    end
    mem_ready = 0;
  endtask

  typedef struct {
    logic          hr, rs, mq, mr;
    logic [P-1:0]  ph;
    logic          ms, hl;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p1, stbs, stb_at, len;
    bit ok;

    tbl[0]  = '{0, 0, 0, 0, 5'b00000, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 5'b00001, 0, 0, 0};
    tbl[2]  = '{0, 0, 1, 1, 5'b00010, 1, 0, 0};
    tbl[3]  = '{1, 0, 0, 0, 5'b00100, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 5'b01000, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 5'b10000, 0, 0, 0};
    tbl[6]  = '{0, 1, 0, 0, 5'b00001, 0, 0, 1};
    tbl[7]  = '{0, 0, 0, 0, 5'b00010, 1, 0, 1};
    tbl[8]  = '{0, 0, 0, 0, 5'b00100, 0, 0, 1};
    tbl[9]  = '{0, 0, 0, 0, 5'b01000, 0, 0, 1};
    tbl[10] = '{1, 0, 0, 0, 5'b10000, 0, 0, 1};
    tbl[11] = '{1, 0, 0, 0, 5'b00000, 0, 1, 2};
    tbl[12] = '{0, 1, 0, 0, 5'b00000, 0, 1, 2};
    tbl[13] = '{1, 1, 0, 0, 5'b00001, 0, 0, 2};
    tbl[14] = '{0, 0, 1, 1, 5'b00010, 1, 0, 2};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      halt_req = tbl[i].hr; resume = tbl[i].rs; mem_req = tbl[i].mq; mem_ready = tbl[i].mr;
      #1;
      chk($sformatf("tbl%0d_phase", i), phase, tbl[i].ph);
      chk($sformatf("tbl%0d_mem_stb", i), mem_stb, tbl[i].ms);
      chk($sformatf("tbl%0d_halted", i), halted, tbl[i].hl);
      chk($sformatf("tbl%0d_count", i), cycle_count, tbl[i].cnt);
      chk($sformatf("tbl%0d_bus_err", i), bus_err, 0);
      tick();
    end

    do_reset();
    for (int i = 0; i < 600; i++) begin
      halt_req  = ($urandom_range(3) == 0);
      resume    = ($urandom_range(2) == 0);
      mem_req   = $urandom_range(1);
      mem_ready = ($urandom_range(2) == 0);
      #1;
      check_model();
      @(posedge clk);
      m_step();
      #1;
    end

    // Ready arrives on the third phase-1 clock.
    do_reset();
    mem_req = 1;
    to_phase0("waitA_find_ph0");
    measure(2, p1, stbs, stb_at, len);
    chk("waitA_ph1_clocks", p1, WEN ? 3 : 1);
    chk("waitA_mem_stb_count", stbs, 1);
    chk("waitA_mem_stb_pos", stb_at, WEN ? 3 : 1);
    chk("waitA_cycle_len", len, WEN ? 7 : 5);
    chk("waitA_bus_err", bus_err, 0);

    // Never ready: timeout after WAIT_MAX waits, sticky bus_err.
    do_reset();
    mem_req = 1;
    to_phase0("tmo_find_ph0");
    measure(-1, p1, stbs, stb_at, len);
    chk("tmo_ph1_clocks", p1, WEN ? 5 : 1);
    chk("tmo_mem_stb_count", stbs, 1);
    chk("tmo_mem_stb_pos", stb_at, WEN ? 5 : 1);
    chk("tmo_cycle_len", len, WEN ? 9 : 5);
    chk("tmo_bus_err", bus_err, WEN);
    mem_req = 0;
    repeat (10) tick();
    chk("tmo_bus_err_sticky", bus_err, WEN);

    // Asynchronous reset while stalled in phase 1.
    mem_req = 1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (phase[1]) begin ok = 1; break; end
      tick();
    end
    chk("arst_find_ph1", ok, 1);
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_phase", phase, 0);
    chk("arst_strobes", {cycle_stb, mem_stb, exec_stb, halted, bus_err}, 0);
    chk("arst_count", cycle_count, 0);
    reset = 1'b1;
    mem_req = 0;
    tick();
    chk("arst_first_phase", phase, 5'b00001);

    // Counter progression and wrap at 2^CNT_WIDTH.
    do_reset();
    to_phase0("wrap_find_ph0");
    repeat (20) tick();
    chk("cnt_after_4", cycle_count, 4);
    chk("cnt_after_4_phase", phase, 5'b00001);
    repeat (55) tick();
    chk("cnt_after_15", cycle_count, 15);
    repeat (5) tick();
    chk("cnt_wrap_16", cycle_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
